// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: instruction field positions, nop encoding and
// datapath widths used by the fetch stage and its hazard logic.
package mips_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 9;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_id_stage_hazard_unit.sv
// Load-use hazard detection: the instruction in IF/ID reads a register that the
// load currently in ID/EX has not yet produced.
module hazard_unit
  import mips_pkg::*;
(
  input  logic            ifid_valid,
  input  logic [XLEN-1:0] ifid_instr,
  input  logic            idex_memread,
  input  logic [4:0]      idex_rt,
  output logic            stall
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (idex_rt == ifid_instr[RS_MSB:RS_LSB]);
  assign rt_hit = (idex_rt == ifid_instr[RT_MSB:RT_LSB]);

  // $zero is never a real dependency, so a load into r0 never stalls.
  assign stall = ifid_valid & idex_memread & (idex_rt != 5'd0) & (rs_hit | rt_hit);

endmodule

// File: rtl/if_id_stage.sv
// MIPS fetch stage: PC register, IF/ID pipeline register, load-use stall and
// ID-resolved redirects, plus saturating stall/flush counters.
module if_id_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_i,
  output logic [31:0]      pc_o,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  input  logic             jump_i,
  input  logic [31:0]      jump_target_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  output logic [31:0]      ifid_instr_o,
  output logic [31:0]      ifid_pc4_o,
  output logic             ifid_valid_o,
  output logic             bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [XLEN-1:0]  pc_p0;
  logic [XLEN-1:0]  instr_p1;
  logic [XLEN-1:0]  pc4_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic             stall;
  logic             redirect;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  pc_plus4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  hazard_unit u_hazard (
    .ifid_valid   (vld_p1),
    .ifid_instr   (instr_p1),
    .idex_memread (idex_memread_i),
    .idex_rt      (idex_rt_i),
    .stall        (stall)
  );

  assign pc_plus4 = pc_p0 + 32'd4;
  assign redirect = ~stall & (branch_taken_i | jump_i);
  assign target   = branch_taken_i ? branch_target_i : jump_target_i;

  // IF -> IF/ID boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_p0     <= RESET_PC;
      instr_p1  <= NOP_INSTR;
      pc4_p1    <= '0;
      vld_p1    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end else if (redirect) begin
      pc_p0     <= target;
      instr_p1  <= NOP_INSTR;
      pc4_p1    <= '0;
      vld_p1    <= 1'b0;
      flush_cnt <= sat_inc(flush_cnt);
    end else begin
      pc_p0    <= pc_plus4;
      instr_p1 <= instr_i;
      pc4_p1   <= pc_plus4;
      vld_p1   <= 1'b1;
    end
  end

  assign pc_o         = pc_p0;
  assign ifid_instr_o = instr_p1;
  assign ifid_pc4_o   = pc4_p1;
  assign ifid_valid_o = vld_p1;
  assign bubble_o     = stall;
  assign stall_cnt_o  = stall_cnt;
  assign flush_cnt_o  = flush_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios plus randomized traffic, all checked
// against a cycle-level reference model of the fetch stage.
module tb_if_id_stage;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      instr_i;
  logic [31:0]      pc_o;
  logic             branch_taken_i;
  logic [31:0]      branch_target_i;
  logic             jump_i;
  logic [31:0]      jump_target_i;
  logic             idex_memread_i;
  logic [4:0]       idex_rt_i;
  logic [31:0]      ifid_instr_o;
  logic [31:0]      ifid_pc4_o;
  logic             ifid_valid_o;
  logic             bubble_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  int vectors = 0;
  int miscompares = 0;
  int mem_mode = 0;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_scnt, m_fcnt;

  if_id_stage #(.RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instr_i(instr_i), .pc_o(pc_o),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i),
    .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
    .ifid_instr_o(ifid_instr_o), .ifid_pc4_o(ifid_pc4_o), .ifid_valid_o(ifid_valid_o),
    .bubble_o(bubble_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  // Instruction memory contents; mode 1 is "add $3,$2,$4" everywhere,
  // mode 2 puts small register numbers in rs/rt so random loads collide.
  function automatic logic [31:0] mem(input logic [31:0] a, input int mode);
    case (mode)
      0:       return 32'h1000_0000 + a;
      1:       return 32'h0044_1820;
      default: return {6'h0, 3'b000, a[3:2], 3'b000, a[5:4], a[15:0]};
    endcase
  endfunction

  always_comb instr_i = mem(pc_o, mem_mode);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_scnt = 0; m_fcnt = 0;
  endtask

  function automatic logic model_stall(input logic mr, input logic [4:0] rt);
    return m_valid && mr && rt != 5'd0 &&
           (rt == m_instr[25:21] || rt == m_instr[20:16]);
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, "_pc"},    pc_o,                m_pc);
    chk({tag, "_instr"}, ifid_instr_o,        m_instr);
    chk({tag, "_pc4"},   ifid_pc4_o,          m_pc4);
    chk({tag, "_valid"}, {31'b0, ifid_valid_o}, {31'b0, m_valid});
    chk({tag, "_scnt"},  {16'b0, stall_cnt_o}, m_scnt);
    chk({tag, "_fcnt"},  {16'b0, flush_cnt_o}, m_fcnt);
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic step(input logic br, input logic [31:0] bt, input logic jp,
                      input logic [31:0] jt, input logic mr, input logic [4:0] rt,
                      input bit check);
    logic st;
    branch_taken_i = br; branch_target_i = bt; jump_i = jp; jump_target_i = jt;
    idex_memread_i = mr; idex_rt_i = rt;
    #1;
    st = model_stall(mr, rt);
    if (check) chk("bubble", {31'b0, bubble_o}, {31'b0, st});
    @(posedge clk);
    if (st) begin
      if (m_scnt < 65535) m_scnt++;
    end else if (br || jp) begin
      m_pc = br ? bt : jt;
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      if (m_fcnt < 65535) m_fcnt++;
    end else begin
      m_instr = mem(m_pc, mem_mode);
      m_pc    = m_pc + 32'd4;
      m_pc4   = m_pc;
      m_valid = 1'b1;
    end
    @(negedge clk);
    if (check) chk_state("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    branch_taken_i = 0; branch_target_i = 0; jump_i = 0; jump_target_i = 0;
    idex_memread_i = 0; idex_rt_i = 0;
    model_reset();
    #2;
    chk_state("reset");
    chk("reset_bubble", {31'b0, bubble_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // sequential fetch
    mem_mode = 0;
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b1);
    chk("first_pc", pc_o, 32'h4);
    chk("first_instr", ifid_instr_o, 32'h1000_0000);
    chk("first_pc4", ifid_pc4_o, 32'h4);
    idle(2);
    chk("seq_pc", pc_o, 32'hC);

    // load-use: IF/ID holds add $3,$2,$4
    mem_mode = 1;
    idle(1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd0, 1'b1);
    chk("rt0_nostall", stall_cnt_o, 16'd0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd2, 1'b1);
    chk("lu_pc_held", pc_o, 32'h14);
    chk("lu_scnt", stall_cnt_o, 16'd1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd2, 1'b1);
    chk("lu_resume", pc_o, 32'h18);

    // taken branch
    step(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 5'd0, 1'b1);
    chk("br_pc", pc_o, 32'h40);
    chk("br_valid", {31'b0, ifid_valid_o}, 32'h0);
    chk("br_fcnt", flush_cnt_o, 16'd1);

    // stall plus branch together, then branch reasserted
    idle(1);
    step(1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 5'd4, 1'b1);
    chk("sb_pc_held", pc_o, 32'h44);
    chk("sb_fcnt", flush_cnt_o, 16'd1);
    step(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 5'd4, 1'b1);
    chk("sb_taken", pc_o, 32'h80);
    chk("sb_fcnt2", flush_cnt_o, 16'd2);

    // branch beats jump; jump to the top of memory, then wrap
    step(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 5'd0, 1'b1);
    chk("br_over_jp", pc_o, 32'h100);
    step(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 5'd0, 1'b1);
    idle(1);
    chk("wrap_pc", pc_o, 32'h0);
    chk("wrap_pc4", ifid_pc4_o, 32'h0);

    // randomized traffic
    mem_mode = 2;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(7) == 0), {$urandom_range(255), 2'b00},
           ($urandom_range(7) == 0), {$urandom_range(255), 2'b00},
           $urandom_range(1) == 1, 5'($urandom_range(3)), 1'b1);
    end

    // stall counter saturation
    mem_mode = 1;
    idle(1);
    for (int i = 0; i < 65540; i++)
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd2, 1'b0);
    chk("sat_scnt", stall_cnt_o, 16'hFFFF);
    chk_state("sat");

    // asynchronous reset in the middle of a stall
    branch_taken_i = 0; jump_i = 0; idex_memread_i = 1; idex_rt_i = 5'd2;
    #1;
    chk("pre_rst_bubble", {31'b0, bubble_o}, 32'h1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_state("async_rst");
    chk("async_rst_bubble", {31'b0, bubble_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd2, 1'b1);
    chk("post_rst_pc", pc_o, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
